dram_read_arbiter_n: RTL
========================

Name: dram_read_arbiter_n

Overview:
- N-channel DRAM read arbiter with in-order return routing. Generalises the two-port read arbiter for tile units with more than two read pipelines.
- Accepts read-address requests from N_CH read pipelines and issues them one at a time on a single DRAM read port.
- Tracks outstanding reads in a tag FIFO so each returned cache line goes to the channel that requested it.
- Adds selectable round-robin or fixed-priority arbitration, a configurable outstanding depth, and an occupancy output.

Parameters:
N_CH, 4, number of requesting read channels (>=2)
GBW, TauCfg::GLOBAL_ADDR_BW, DRAM address width
DBW, TauCfg::DATA_BW, data word width
CSIZE, TauCfg::CACHE_SIZE, words per DRAM line
DEPTH, 4, maximum outstanding reads (tag FIFO depth, >=1)
RR, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_ch_dramra_rdy  in  N_CH  per-channel address request valid
o_ch_dramra_ack  out  N_CH  per-channel address accept, one-hot pulse
i_ch_dramra  in  N_CH x GBW  per-channel request address
o_ch_dramrd_rdy  out  N_CH  per-channel returned-line valid
i_ch_dramrd_ack  in  N_CH  per-channel returned-line accept
o_ch_dramrd  out  CSIZE x DBW  returned line, broadcast to all channels
o_dramra_rdy  out  1  DRAM address valid
i_dramra_ack  in  1  DRAM address accept
o_dramra  out  GBW  DRAM address
i_dramrd_rdy  in  1  DRAM line valid
o_dramrd_ack  out  1  DRAM line accept
i_dramrd  in  CSIZE x DBW  DRAM line
o_outstanding  out  clog2(DEPTH+1)  current tag FIFO occupancy

Behaviour:
Handshake rules (rdy/ack):
- A transfer occurs in a cycle where rdy && ack.
- rdy, once high, stays high with stable payload until ack.

Address issue:
- A grant is allowed in a cycle when (!o_dramra_rdy || i_dramra_ack) && count < DEPTH && |i_ch_dramra_rdy.
- On a grant:
  - pulse o_ch_dramra_ack[g] combinationally in the same cycle;
  - register i_ch_dramra[g] into o_dramra;
  - set o_dramra_rdy on the next edge;
  - push tag g into the FIFO.
- The FIFO reserves the slot at grant time, not at DRAM accept.
- On i_dramra_ack with no new grant, clear o_dramra_rdy. o_dramra holds its last value.
- Throughput: one address per cycle when DRAM acks every cycle.

Arbitration:
- RR=1: the rotating pointer starts at the index after the last granted channel. It updates only on a grant and resets to 0.
- RR=0: the lowest set index wins every time. Starvation is permitted.

Data return (combinational, zero latency):
- o_ch_dramrd_rdy[k] = i_dramrd_rdy && count!=0 && head==k.
- o_dramrd_ack = i_ch_dramrd_ack[head] && count!=0.
- o_ch_dramrd = i_dramrd.
- Pop the FIFO on i_dramrd_rdy && o_dramrd_ack.

Tag FIFO:
- Depth DEPTH, each entry clog2(N_CH) bits, with read/write pointers and a count.
- Simultaneous push and pop: count unchanged.
- No same-cycle bypass: when count==DEPTH a grant is blocked even if a pop occurs that cycle.

Boundary conditions:
- i_dramrd_rdy while count==0: protocol violation. Hold o_dramrd_ack=0 and flag it with a simulation assertion.
- A channel that drops rdy before ack: protocol violation, assertion.
- A request to a channel whose own line is still pending is allowed; lines return in issue order.

Reset (async, immediate):
- o_dramra_rdy=0, o_dramra=0, o_ch_dramra_ack=0, o_ch_dramrd_rdy=0, o_dramrd_ack=0, o_outstanding=0.
- FIFO is emptied and the RR pointer goes to 0.
- Reset mid-operation discards in-flight tags; the DRAM side must be reset together with this block.

Decomposition:
- Shared package TauCfg gains DRAM_OUTSTANDING (default DEPTH) and N_RD_CH (default N_CH). The tag width is derived locally.
- One sub-module: dram_tag_fifo (parametrised width/depth; push/pop/count/head; async active-high reset).
- The arbiter logic stays in the top module.

Test Plan:
- Reset: assert i_rst mid-run with 2 outstanding -> all outputs 0 immediately, o_outstanding=0, next request to ch2 is granted first.
- Single request: ch1 addr 0x0100 -> o_ch_dramra_ack=0010 that cycle, o_dramra_rdy=1 / o_dramra=0x0100 next cycle. DRAM line then gives o_ch_dramrd_rdy=0010, and o_outstanding steps 1->0.
- RR contention: ch0..ch3 all requesting, DRAM acks every cycle -> grants 0,1,2,3,0 on consecutive cycles. Returned lines route 0,1,2,3 in order.
- Full FIFO: DEPTH=4, four grants, no data returned -> fifth request stays un-acked. One line popped -> grant the following cycle.
- Fixed priority (RR=0): ch0 and ch3 both requesting continuously -> ch3 never granted while ch0 requests.
- Backpressure: ch2's i_ch_dramrd_ack held low 5 cycles -> o_dramrd_ack=0 for 5 cycles, o_ch_dramrd stable, and the other channels are not signalled.

Source files
------------

// File: rtl/dram_read_arbiter_n_pkg.sv
// TauCfg: shared tile configuration constants and index-width helper
package TauCfg;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW = 16;
  localparam int CACHE_SIZE = 4;
  localparam int DRAM_OUTSTANDING = 4;
  localparam int N_RD_CH = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dram_read_arbiter_n_tag_fifo.sv
// dram_tag_fifo: FIFO of channel tags, one per outstanding DRAM read
// Ports: clk, rst (async active-high); push/din append a tag; pop retires the
//        oldest tag; head is the oldest tag; count is the occupancy.
module dram_tag_fifo
  import TauCfg::*;
#(
  parameter int W = 2,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int PW = idx_w(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] step(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= step(wp);
      if (pop) rp <= step(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rp];
endmodule

// File: rtl/dram_read_arbiter_n.sv
// dram_read_arbiter_n: N-channel DRAM read arbiter with in-order line return
// Ports: i_clk, i_rst (async active-high); i_ch_dramra_rdy/o_ch_dramra_ack/
//        i_ch_dramra per-channel address requests; o_ch_dramrd_rdy/
//        i_ch_dramrd_ack/o_ch_dramrd per-channel line return; o_dramra_rdy/
//        i_dramra_ack/o_dramra DRAM address port; i_dramrd_rdy/o_dramrd_ack/
//        i_dramrd DRAM line port; o_outstanding tag FIFO occupancy.
module dram_read_arbiter_n
  import TauCfg::*;
#(
  parameter int N_CH = N_RD_CH,
  parameter int GBW = GLOBAL_ADDR_BW,
  parameter int DBW = DATA_BW,
  parameter int CSIZE = CACHE_SIZE,
  parameter int DEPTH = DRAM_OUTSTANDING,
  parameter int RR = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_CH-1:0]                 i_ch_dramra_rdy,
  output logic [N_CH-1:0]                 o_ch_dramra_ack,
  input  logic [N_CH-1:0][GBW-1:0]        i_ch_dramra,
  output logic [N_CH-1:0]                 o_ch_dramrd_rdy,
  input  logic [N_CH-1:0]                 i_ch_dramrd_ack,
  output logic [CSIZE-1:0][DBW-1:0]       o_ch_dramrd,
  output logic                            o_dramra_rdy,
  input  logic                            i_dramra_ack,
  output logic [GBW-1:0]                  o_dramra,
  input  logic                            i_dramrd_rdy,
  output logic                            o_dramrd_ack,
  input  logic [CSIZE-1:0][DBW-1:0]       i_dramrd,
  output logic [CW-1:0]                   o_outstanding
);
  localparam int TW = idx_w(N_CH);
  logic [TW-1:0] ptr, gnt_idx, head;
  logic [CW-1:0] count;
  logic grant, pop, found;
  int base;
  always_comb begin
    base = RR != 0 ? int'(ptr) : 0;
    found = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (!found && i_ch_dramra_rdy[(base + i) % N_CH]) begin
        found = 1'b1;
        gnt_idx = TW'((base + i) % N_CH);
      end
  end
  // The FIFO slot is reserved at grant, so a full FIFO blocks even when a pop
  // lands in the same cycle.
  assign grant = !i_rst && (!o_dramra_rdy || i_dramra_ack) && count < CW'(DEPTH) && |i_ch_dramra_rdy;
  assign o_ch_dramra_ack = grant ? N_CH'(1) << gnt_idx : '0;
  assign o_ch_dramrd_rdy = (i_dramrd_rdy && count != '0) ? N_CH'(1) << head : '0;
  assign o_dramrd_ack = count != '0 && i_ch_dramrd_ack[head];
  assign pop = i_dramrd_rdy && o_dramrd_ack;
  assign o_ch_dramrd = i_dramrd;
  assign o_outstanding = count;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_dramra_rdy <= 1'b0;
      o_dramra <= '0;
      ptr <= '0;
    end else if (grant) begin
      o_dramra_rdy <= 1'b1;
      o_dramra <= i_ch_dramra[gnt_idx];
      ptr <= gnt_idx == TW'(N_CH - 1) ? '0 : gnt_idx + 1'b1;
    end else if (i_dramra_ack) begin
      o_dramra_rdy <= 1'b0;
    end
  dram_tag_fifo #(.W(TW), .DEPTH(DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(grant),
    .din(gnt_idx),
    .pop(pop),
    .head(head),
    .count(count)
  );
  // A line with nothing outstanding cannot be routed anywhere.
  assert property (@(posedge i_clk) disable iff (i_rst) !(i_dramrd_rdy && count == '0));
  for (genvar g = 0; g < N_CH; g++) begin : g_hold
    assert property (@(posedge i_clk) disable iff (i_rst)
      i_ch_dramra_rdy[g] && !o_ch_dramra_ack[g] |=> i_ch_dramra_rdy[g] && $stable(i_ch_dramra[g]));
  end
endmodule
